writeback_stage: RTL

Final pipeline stage of the NaiveMIPS core, directly upstream of the general register file. It takes one retiring instruction per handshake from the memory stage, waits for the data-bus response when the instruction is a load, and aligns and extends the load data. It then drives the register-file write port for exactly one cycle per instruction. It also exposes a forwarding port and a pending-load destination for the hazard unit.

---
 rtl/writeback_stage.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/writeback_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : writeback_stage                                              |
// | Description : Final NaiveMIPS pipeline stage. Accepts one retiring         |
// |               instruction per handshake, waits for the data-bus response   |
// |               of loads, aligns/extends load data and drives the register   |
// |               file write port for exactly one cycle per instruction.       |
// |               Also exposes a forwarding port and the pending-load dst.     |
// | Options     : WB_LOAD_ALIGN_EN - byte/halfword extraction and extension.   |
// |               When undefined every load commits dbus_rdata unmodified.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module writeback_stage (
  input  logic        clk,
  input  logic        reset,
  // memory-stage handshake
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_dst,
  input  logic [31:0] in_result,
  input  logic        in_is_load,
  input  logic [2:0]  in_load_type,
  input  logic [1:0]  in_addr_low,
  // data-bus load response
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  // register-file write port
  output logic [4:0]  grf_waddr,
  output logic [31:0] grf_wdata,
  output logic [31:0] wb_pc,
  // hazard unit
  output logic        fwd_valid,
  output logic [4:0]  fwd_addr,
  output logic [31:0] fwd_data,
  output logic        pend_valid,
  output logic [4:0]  pend_dst
);

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    FULL      = 2'd1,
    WAIT_LOAD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_pc;
  logic [4:0]  r_dst;
  logic [31:0] r_result;
  logic [31:0] r_last_pc;     // PC of the most recent commit, shown between commits

  logic        w_transfer;
  logic        w_take_resp;
  logic        w_commit;
  logic [31:0] w_load_data;

  assign in_ready    = (r_state != WAIT_LOAD);
  assign w_transfer  = in_valid && in_ready;
  assign w_take_resp = (r_state == WAIT_LOAD) && dbus_rvalid;
  assign w_commit    = (r_state == FULL);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: a committing slot drains to EMPTY unless refilled
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      EMPTY, FULL: begin
        if (w_transfer) begin
          w_state_next = in_is_load ? WAIT_LOAD : FULL;
        end else begin
          w_state_next = EMPTY;
        end
      end
      WAIT_LOAD: begin
        if (dbus_rvalid) begin
          w_state_next = FULL;
        end
      end
      default: w_state_next = EMPTY;
    endcase
  end

  // Instruction capture; the result comes from the ALU or, for loads, the bus
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= 32'd0;
      r_dst     <= 5'd0;
      r_result  <= 32'd0;
      r_last_pc <= 32'd0;
    end else begin
      if (w_transfer) begin
        r_pc  <= in_pc;
        r_dst <= in_dst;
        if (!in_is_load) begin
          r_result <= in_result;
        end
      end else if (w_take_resp) begin
        r_result <= w_load_data;
      end
      if (w_commit) begin
        r_last_pc <= r_pc;
      end
    end
  end

`ifdef WB_LOAD_ALIGN_EN
  localparam logic [2:0] c_LD_LB  = 3'd1;
  localparam logic [2:0] c_LD_LBU = 3'd2;
  localparam logic [2:0] c_LD_LH  = 3'd3;
  localparam logic [2:0] c_LD_LHU = 3'd4;

  logic [2:0]  r_load_type;
  logic [1:0]  r_addr_low;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Load shape captured with the load so the response can be aligned later
  always_ff @(posedge clk) begin
    if (reset) begin
      r_load_type <= 3'd0;
      r_addr_low  <= 2'd0;
    end else if (w_transfer && in_is_load) begin
      r_load_type <= in_load_type;
      r_addr_low  <= in_addr_low;
    end
  end

  // Byte/half extraction (little-endian) and sign/zero extension;
  // addr_low[0] is irrelevant for halves since misalignment traps upstream
  always_comb begin
    w_byte = dbus_rdata[7:0];
    case (r_addr_low)
      2'd0:    w_byte = dbus_rdata[7:0];
      2'd1:    w_byte = dbus_rdata[15:8];
      2'd2:    w_byte = dbus_rdata[23:16];
      default: w_byte = dbus_rdata[31:24];
    endcase
    w_half = r_addr_low[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    case (r_load_type)
      c_LD_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
      c_LD_LBU: w_load_data = {24'd0, w_byte};
      c_LD_LH:  w_load_data = {{16{w_half[15]}}, w_half};
      c_LD_LHU: w_load_data = {16'd0, w_half};
      default:  w_load_data = dbus_rdata;
    endcase
  end
`else
  logic w_unused_align;

  // Without alignment every load behaves as LW; load shape inputs are unused
  assign w_load_data    = dbus_rdata;
  assign w_unused_align = ^{in_load_type, in_addr_low};
`endif

  // Commit, forwarding and pending-load outputs
  assign grf_waddr  = w_commit ? r_dst : 5'd0;
  assign grf_wdata  = w_commit ? r_result : 32'd0;
  assign wb_pc      = w_commit ? r_pc : r_last_pc;
  assign fwd_valid  = w_commit && (r_dst != 5'd0);
  assign fwd_addr   = grf_waddr;
  assign fwd_data   = grf_wdata;
  assign pend_valid = (r_state == WAIT_LOAD);
  assign pend_dst   = pend_valid ? r_dst : 5'd0;

endmodule
`default_nettype wire
